matrix_filter3x3: RTL

MATRIX_FILTER3X3 -- requirements
Module: matrix_filter3x3

---
 rtl/matrix_filter_pkg.sv | 27 ++
 rtl/matrix_filter3x3_window3x3.sv | 56 +++++
 rtl/matrix_filter3x3.sv | 125 ++++++++++++
 3 files changed

// File: rtl/matrix_filter_pkg.sv
// matrix_filter_pkg
//   Shared constants for the 3x3 matrix filter.
//   - mode_e      : kernel select encoding (gaussian, box8, pass)
//   - COL_W       : width of the per-line column counter
//   - GAUSS_SH    : normalising shift of the 1-2-1 kernel (weights sum to 16)
//   - BOX_SH      : normalising shift of the 8-neighbour box (8 taps)
//   - sum_w()     : intermediate sum width rule, pixel width + 4 guard bits
package matrix_filter_pkg;

  typedef enum logic [1:0] {
    MODE_GAUSS = 2'd0,
    MODE_BOX8  = 2'd1,
    MODE_PASS  = 2'd2,
    MODE_PASS3 = 2'd3   // second encoding of pass-through
  } mode_e;

  localparam int COL_W    = 11;
  localparam int GAUSS_SH = 4;
  localparam int BOX_SH   = 3;

  // Gaussian weights sum to 16, so four guard bits always hold the full sum
  // (including the optional +8 rounding term) without overflow.
  function automatic int sum_w(input int width);
    return width + 4;
  endfunction

endpackage

// File: rtl/matrix_filter3x3_window3x3.sv
// window3x3
//   Sliding 3x3 window and per-line column counter.
//   The two older columns are registered; the newest column is the incoming
//   one, so win_nxt is the complete window that a column accepted this cycle
//   closes. Window and counter only move on valid_in.
// Ports
//   clk, rst_n  : clock, async active-low reset
//   valid_in    : din column is valid this cycle
//   sol         : start of line (only with valid_in), restarts col at 0
//   col_in      : [0]=top, [1]=middle, [2]=bottom pixel of the column
//   win_nxt     : [col][row] window, col 0 = newest (col_in), col 2 = oldest
//   win_ok      : accepted column completes a window from a single line
module window3x3
  import matrix_filter_pkg::*;
#(
  parameter int PIC_WIDTH = 250,
  parameter int WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic                         sol,
  input  logic [2:0][WIDTH-1:0]        col_in,
  output logic [2:0][2:0][WIDTH-1:0]   win_nxt,
  output logic                         win_ok
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIC_WIDTH - 1);

  logic [1:0][2:0][WIDTH-1:0] win_q;   // [0] = previous column, [1] = one before
  logic [COL_W-1:0]           col;
  logic [COL_W-1:0]           col_nxt;

  always_comb begin
    col_nxt = col;
    if (sol)                  col_nxt = '0;
    else if (col == COL_LAST) col_nxt = '0;
    else                      col_nxt = col + COL_W'(1);
  end

  // Once col reaches 2 every column of the window belongs to the current
  // line; a mid-line sol therefore drops the partial line automatically.
  assign win_ok  = valid_in && (col_nxt >= COL_W'(2));
  assign win_nxt = {win_q[1], win_q[0], col_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      col   <= '0;
    end else if (valid_in) begin
      win_q <= win_nxt[1:0];
      col   <= col_nxt;
    end
  end

endmodule

// File: rtl/matrix_filter3x3.sv
// matrix_filter3x3
//   3x3 image filter fed one pixel column per valid cycle.
//   Pipeline: window (window3x3) -> sum stage -> output register, so a
//   column accepted in cycle t shows on valid_out/dout in cycle t+2.
//   After the window the pipeline free-runs; gaps in valid_in never stall it.
//   Kernels (mode, sampled with the sum stage):
//     0 gaussian 1 2 1 / 2 4 2 / 1 2 1, >> 4
//     1 box8     8 neighbours, centre excluded, >> 3
//     2,3 pass   centre pixel
//   Optional macro ROUND_EN: add half an LSB before the shift (+8 / +4);
//   without it the result truncates.
// Ports
//   clk, rst_n         : clock, async active-low reset
//   valid_in, sol      : column strobe and start-of-line marker
//   din1, din2, din3   : top / middle / bottom pixel of the column
//   mode               : kernel select
//   valid_out, dout    : filtered pixel; dout holds while valid_out is low
module matrix_filter3x3
  import matrix_filter_pkg::*;
#(
  parameter int PIC_WIDTH = 250,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             sol,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [1:0]       mode,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout
);

  localparam int SUM_W  = sum_w(WIDTH);
  localparam int STAGES = 2;

`ifdef ROUND_EN
  localparam logic [SUM_W-1:0] G_RND = SUM_W'(8);
  localparam logic [SUM_W-1:0] B_RND = SUM_W'(4);
`else
  localparam logic [SUM_W-1:0] G_RND = '0;
  localparam logic [SUM_W-1:0] B_RND = '0;
`endif

  typedef struct packed {
    logic [SUM_W-1:0] gauss;
    logic [SUM_W-1:0] box;
    logic [WIDTH-1:0] ctr;
    mode_e            mode;
  } sum_t;

  // ---------------------------------------------------------------- window
  logic [2:0][2:0][WIDTH-1:0] w;
  logic                       win_ok;

  window3x3 #(
    .PIC_WIDTH (PIC_WIDTH),
    .WIDTH     (WIDTH)
  ) u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .sol      (sol),
    .col_in   ({din3, din2, din1}),
    .win_nxt  (w),
    .win_ok   (win_ok)
  );

  // --------------------------------------------------------------- kernels
  function automatic logic [SUM_W-1:0] ext(input logic [WIDTH-1:0] p);
    return SUM_W'(p);
  endfunction

  logic [SUM_W-1:0] corners, edges;
  sum_t             sum_d, sum_q;

  // w[col][row]; corners and edges are shared by both kernels.
  always_comb begin
    corners     = ext(w[0][0]) + ext(w[0][2]) + ext(w[2][0]) + ext(w[2][2]);
    edges       = ext(w[0][1]) + ext(w[2][1]) + ext(w[1][0]) + ext(w[1][2]);
    sum_d.gauss = corners + (edges << 1) + (ext(w[1][1]) << 2) + G_RND;
    sum_d.box   = corners + edges + B_RND;
    sum_d.ctr   = w[1][1];
    sum_d.mode  = mode_e'(mode);
  end

  // -------------------------------------------------- sum stage / valids
  logic [STAGES-1:0] vld_pipe;   // [0] sum stage, [1] output register

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sum_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], win_ok};
      if (win_ok) sum_q <= sum_d;
    end
  end

  // --------------------------------------------------------- output stage
  // Sums never exceed (2^WIDTH-1) << shift, so the cast drops only zeros.
  logic [WIDTH-1:0] res;

  always_comb begin
    res = sum_q.ctr;
    case (sum_q.mode)
      MODE_GAUSS: res = WIDTH'(sum_q.gauss >> GAUSS_SH);
      MODE_BOX8:  res = WIDTH'(sum_q.box >> BOX_SH);
      default:    res = sum_q.ctr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (vld_pipe[0]) begin
      dout <= res;
    end
  end

  assign valid_out = vld_pipe[STAGES-1];

endmodule
